// File: rtl/logic_reduce_pipe.sv
// Reduces each accepted vector to AND/OR/XOR/majority and queues the results, tagged, in a small FIFO.
// Optional self-test pattern generator compiled in with LOGIC_REDUCE_SELF_TEST_EN.
module logic_reduce_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_and,
    output logic                       out_or,
    output logic                       out_xor,
    output logic                       out_maj,
    output logic [7:0]                 out_tag,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       st_start,
    output logic                       st_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [7:0] tag;
        logic       r_and;
        logic       r_or;
        logic       r_xor;
        logic       r_maj;
    } res_t;

    res_t             mem_q [DEPTH];
    res_t             mem_d [DEPTH];
    res_t             new_res;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       tag_q, tag_d;
    logic [WIDTH-1:0] push_vec;
    logic [4:0]       pop_cnt;
    logic             full, push_en, pop_en, st_push;

    assign full = (level_q == LW'(DEPTH));

`ifdef LOGIC_REDUCE_SELF_TEST_EN
    typedef enum logic {ST_IDLE, ST_RUN} st_state_t;
    st_state_t        st_state_q, st_state_d;
    logic [WIDTH-1:0] st_cnt_q, st_cnt_d;

    always_comb begin
        st_state_d = st_state_q;
        st_cnt_d   = st_cnt_q;
        st_push    = 1'b0;
        case (st_state_q)
            ST_IDLE: if (st_start) begin
                st_state_d = ST_RUN;
                st_cnt_d   = '0;
            end
            ST_RUN: if (!full) begin
                st_push = 1'b1;
                if (st_cnt_q == {WIDTH{1'b1}}) st_state_d = ST_IDLE;
                else                           st_cnt_d   = st_cnt_q + 1'b1;
            end
            default: st_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_state_q <= ST_IDLE;
            st_cnt_q   <= '0;
        end else begin
            st_state_q <= st_state_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    assign st_busy  = (st_state_q == ST_RUN);
    assign push_vec = st_busy ? st_cnt_q : in_vec;
`else
    logic st_start_unused;
    assign st_start_unused = st_start;
    assign st_push         = 1'b0;
    assign st_busy         = 1'b0;
    assign push_vec        = in_vec;
`endif

    // No pass-through: a full FIFO refuses input even if the head pops this cycle.
    assign in_ready  = !full && !st_busy;
    assign out_valid = (level_q != '0);
    assign push_en   = (in_valid && in_ready) || st_push;
    assign pop_en    = out_valid && out_ready;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) pop_cnt = pop_cnt + 5'(push_vec[i]);
        new_res.tag   = tag_q;
        new_res.r_and = &push_vec;
        new_res.r_or  = |push_vec;
        new_res.r_xor = ^push_vec;
        new_res.r_maj = (pop_cnt > 5'(WIDTH / 2));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q;
        level_d  = level_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = new_res;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            tag_d           = tag_q + 8'd1;
        end
        if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tag_q    <= tag_d;
        end
    end

    // Payload storage needs no reset; level gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    assign out_and = mem_q[rd_ptr_q].r_and;
    assign out_or  = mem_q[rd_ptr_q].r_or;
    assign out_xor = mem_q[rd_ptr_q].r_xor;
    assign out_maj = mem_q[rd_ptr_q].r_maj;
    assign out_tag = mem_q[rd_ptr_q].tag;
    assign level   = level_q;
endmodule
